mac_job_scheduler: RTL and testbench

MAC_JOB_SCHEDULER -- requirements
Module: mac_job_scheduler

---
 rtl/mac_sched_pkg.sv | 16 +
 rtl/job_fifo.sv | 66 ++++++
 rtl/mac_job_scheduler.sv | 112 +++++++++++
 tb/tb_mac_job_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// rtl/mac_sched_pkg.sv - shared state encoding and default sizing for the MAC job scheduler
package mac_sched_pkg;

    localparam int DEF_SIZE    = 6;
    localparam int DEF_SETS    = 16;
    localparam int DEF_DEPTH   = 2;
    localparam int DEF_TIMEOUT = 160;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } sched_state_t;

endpackage

// File: rtl/job_fifo.sv
// rtl/job_fifo.sv - power-of-two job queue with registered full/empty flags
module job_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    // A push into a full queue is only safe when the head leaves on the same edge.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/mac_job_scheduler.sv
// rtl/mac_job_scheduler.sv - queues MAC jobs, issues them one at a time, times out stalled ones
module mac_job_scheduler
    import mac_sched_pkg::*;
#(
    parameter int SIZE    = DEF_SIZE,
    parameter int SETS    = DEF_SETS,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SETS*SIZE-1:0]   in_a,
    input  logic [SETS*SIZE-1:0]   in_b,
    input  logic [SETS*SIZE-1:0]   in_c,
    output logic                   mac_valid,
    output logic [SETS*SIZE-1:0]   mac_a,
    output logic [SETS*SIZE-1:0]   mac_b,
    output logic [SETS*SIZE-1:0]   mac_c,
    input  logic                   mac_ready,
    input  logic [2*SIZE+SETS-1:0] mac_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2*SIZE+SETS-1:0] res_data,
    output logic                   err_timeout,
    output logic [15:0]            jobs_done
);

    localparam int OW = SETS * SIZE;
    localparam int JW = 3 * OW;
    localparam int CW = $clog2(TIMEOUT + 1);

    sched_state_t  state;
    logic [CW-1:0] wait_cnt;
    logic [JW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    // in_ready comes straight off the queue's registered full flag.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && !fifo_empty && !res_valid;

    job_fifo #(
        .WIDTH (JW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({in_c, in_b, in_a}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mac_valid   <= 1'b0;
            mac_a       <= '0;
            mac_b       <= '0;
            mac_c       <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            err_timeout <= 1'b0;
            jobs_done   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        {mac_c, mac_b, mac_a} <= head;
                        mac_valid             <= 1'b1;
                        state                 <= ISSUE;
                    end
                end
                ISSUE: begin
                    mac_valid <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // WAIT lasts at most TIMEOUT cycles; a reply in the last one still wins.
                    if (mac_ready) begin
                        res_data  <= mac_out;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        jobs_done <= jobs_done + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_job_scheduler.sv
// tb/tb_mac_job_scheduler.sv - randomized and directed bench against a queue-level scheduler model
module tb_mac_job_scheduler;

    localparam int SIZE    = 6;
    localparam int SETS    = 16;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 160;
    localparam int OW      = SETS * SIZE;
    localparam int RW      = 2 * SIZE + SETS;
    localparam int JW      = 3 * OW;

    localparam int M_FREE   = 0;
    localparam int M_START  = 1;
    localparam int M_BUSY   = 2;
    localparam int M_RESULT = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] in_a = '0;
    logic [OW-1:0] in_b = '0;
    logic [OW-1:0] in_c = '0;
    logic          mac_valid;
    logic [OW-1:0] mac_a;
    logic [OW-1:0] mac_b;
    logic [OW-1:0] mac_c;
    logic          mac_ready = 1'b0;
    logic [RW-1:0] mac_out = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [RW-1:0] res_data;
    logic          err_timeout;
    logic [15:0]   jobs_done;

    int checks = 0;
    int errors = 0;

    mac_job_scheduler #(
        .SIZE    (SIZE),
        .SETS    (SETS),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_c        (in_c),
        .mac_valid   (mac_valid),
        .mac_a       (mac_a),
        .mac_b       (mac_b),
        .mac_c       (mac_c),
        .mac_ready   (mac_ready),
        .mac_out     (mac_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .err_timeout (err_timeout),
        .jobs_done   (jobs_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [JW-1:0] act, input logic [JW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference MAC: sum over all sets of a*b+c.
    function automatic logic [RW-1:0] mac_fn(input logic [JW-1:0] j);
        int acc = 0;
        for (int s = 0; s < SETS; s++) begin
            acc += int'(j[s*SIZE +: SIZE]) * int'(j[OW + s*SIZE +: SIZE]) + int'(j[2*OW + s*SIZE +: SIZE]);
        end
        return RW'(acc);
    endfunction

    function automatic logic [JW-1:0] rand_job();
        logic [JW-1:0] r;
        for (int k = 0; k < JW / 32; k++) begin
            r[k*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    // Stimulus knobs set by the main sequence
    logic          drv_en = 1'b0;
    logic          chk_en = 1'b0;
    int            submit_left = 0;
    int            p_valid = 100;
    int            p_ready = 100;
    int            p_spur = 0;
    int            fixed_lat = -1;
    logic          fixed_en = 1'b0;
    logic [JW-1:0] fixed_job = '0;
    logic [JW-1:0] sub_log [$];
    int            lat_tab [8] = '{1, 2, 3, 7, TIMEOUT - 1, TIMEOUT, TIMEOUT + 1, 0};

    int            cd = 0;
    logic [RW-1:0] pend_out = '0;

    // Input driver and MAC model; everything changes on the falling edge.
    always @(negedge clk) begin
        logic [JW-1:0] job;
        int            lat;
        if (!drv_en) begin
            in_valid  = 1'b0;
            res_ready = 1'b0;
            mac_ready = 1'b0;
        end else begin
            in_valid = (submit_left > 0) && (int'($urandom_range(99)) < p_valid);
            if (in_valid) begin
                job = fixed_en ? fixed_job : rand_job();
                {in_c, in_b, in_a} = job;
                if (in_ready) begin
                    submit_left--;
                    sub_log.push_back(job);
                end
            end
            res_ready = int'($urandom_range(99)) < p_ready;
            mac_ready = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mac_ready = 1'b1;
                    mac_out   = pend_out;
                end
            end else if (int'($urandom_range(99)) < p_spur) begin
                mac_ready = 1'b1;
                mac_out   = RW'($urandom);
            end
            if (mac_valid) begin
                lat      = (fixed_lat >= 0) ? fixed_lat : lat_tab[$urandom_range(7)];
                pend_out = mac_fn({mac_c, mac_b, mac_a});
                cd       = lat;
            end
        end
    end

    // Behavioural model: job queue plus a single in-flight job slot.
    logic [JW-1:0] m_q [$];
    int            m_phase = M_FREE;
    int            m_waited = 0;
    logic [JW-1:0] m_cur = '0;
    logic [RW-1:0] m_res = '0;
    logic          m_err = 1'b0;
    logic [15:0]   m_done = '0;

    always @(posedge clk) begin
        logic accept;
        if (reset) begin
            m_q.delete();
            m_phase  = M_FREE;
            m_waited = 0;
            m_cur    = '0;
            m_res    = '0;
            m_err    = 1'b0;
            m_done   = '0;
        end else begin
            accept = in_valid && (m_q.size() < DEPTH);
            if (m_phase == M_RESULT) begin
                if (res_ready) begin
                    m_phase = M_FREE;
                    m_done  = m_done + 16'd1;
                end
            end else if (m_phase == M_BUSY) begin
                m_waited++;
                if (mac_ready) begin
                    m_res   = mac_out;
                    m_phase = M_RESULT;
                end else if (m_waited == TIMEOUT) begin
                    m_err   = 1'b1;
                    m_phase = M_FREE;
                end
            end else if (m_phase == M_START) begin
                m_phase  = M_BUSY;
                m_waited = 0;
            end else if (m_q.size() > 0) begin
                m_cur   = m_q.pop_front();
                m_phase = M_START;
            end
            if (accept) begin
                m_q.push_back({in_c, in_b, in_a});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", JW'(in_ready), JW'(m_q.size() < DEPTH));
            chk("mac_valid", JW'(mac_valid), JW'(m_phase == M_START));
            chk("mac_ops", {mac_c, mac_b, mac_a}, m_cur);
            chk("res_valid", JW'(res_valid), JW'(m_phase == M_RESULT));
            chk("res_data", JW'(res_data), JW'(m_res));
            chk("err_timeout", JW'(err_timeout), JW'(m_err));
            chk("jobs_done", JW'(jobs_done), JW'(m_done));
        end
    end

    task automatic run_collect(input int n, output logic [RW-1:0] log_q [$], output int saw_full);
        log_q.delete();
        saw_full = 0;
        repeat (n) begin
            @(negedge clk);
            if (res_valid) log_q.push_back(res_data);
            if (!in_ready) saw_full = 1;
        end
    endtask

    initial begin
        logic [RW-1:0] res_log [$];
        logic [RW-1:0] hold_val;
        int            saw_full;
        int            t_mv;
        int            t_rv;
        int            t_err;
        int            n_mv;
        int            found;
        int            stable;

        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("rst_in_ready", JW'(in_ready), JW'(1));
        chk("rst_mac_valid", JW'(mac_valid), JW'(0));
        chk("rst_res_valid", JW'(res_valid), JW'(0));
        chk("rst_jobs_done", JW'(jobs_done), JW'(0));

        // Single job of all-2/all-3/all-1 with a 70-cycle MAC
        for (int s = 0; s < SETS; s++) begin
            fixed_job[s*SIZE +: SIZE]          = SIZE'(2);
            fixed_job[OW + s*SIZE +: SIZE]     = SIZE'(3);
            fixed_job[2*OW + s*SIZE +: SIZE]   = SIZE'(1);
        end
        fixed_en    = 1'b1;
        fixed_lat   = 70;
        drv_en      = 1'b1;
        submit_left = 1;
        t_mv = -1; t_rv = -1; n_mv = 0; hold_val = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mac_valid) begin n_mv++; t_mv = i; end
            if (res_valid && t_rv < 0) begin t_rv = i; hold_val = res_data; end
        end
        chk("single_mac_pulses", JW'(n_mv), JW'(1));
        chk("single_latency", JW'(t_rv - t_mv), JW'(71));
        chk("single_res_data", JW'(hold_val), JW'(112));
        chk("single_jobs_done", JW'(jobs_done), JW'(1));
        fixed_en = 1'b0;

        // Three back-to-back jobs against a busy MAC
        sub_log.delete();
        fixed_lat   = 40;
        submit_left = 3;
        run_collect(300, res_log, saw_full);
        chk("b2b_saw_full", JW'(saw_full), JW'(1));
        chk("b2b_results", JW'(res_log.size()), JW'(3));
        for (int i = 0; i < res_log.size() && i < sub_log.size(); i++) begin
            chk("b2b_order", JW'(res_log[i]), JW'(mac_fn(sub_log[i])));
        end

        // Result held back for 50 cycles
        p_ready     = 0;
        fixed_lat   = 5;
        submit_left = 2;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (res_valid) found = 1;
        end
        chk("hold_res_wait", JW'(found), JW'(1));
        hold_val = res_data;
        stable = 1; n_mv = 0;
        repeat (50) begin
            @(negedge clk);
            if (res_data !== hold_val || !res_valid) stable = 0;
            if (mac_valid) n_mv++;
        end
        chk("hold_stable", JW'(stable), JW'(1));
        chk("hold_no_issue", JW'(n_mv), JW'(0));
        p_ready = 100;
        repeat (100) @(negedge clk);
        chk("hold_jobs_done", JW'(jobs_done), JW'(6));

        // MAC never answers, then a normal job
        fixed_lat   = 0;
        submit_left = 1;
        t_mv = -1; t_err = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (mac_valid) t_mv = i;
            if (err_timeout && t_err < 0) t_err = i;
        end
        chk("timeout_cycle", JW'(t_err - t_mv), JW'(TIMEOUT + 1));
        fixed_lat   = 10;
        submit_left = 1;
        repeat (100) @(negedge clk);
        chk("after_timeout_done", JW'(jobs_done), JW'(7));
        chk("timeout_sticky", JW'(err_timeout), JW'(1));

        // Reset ten cycles into WAIT; the late MAC reply must be ignored
        fixed_lat   = 30;
        submit_left = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mac_valid) found = 1;
        end
        chk("rst_job_issued", JW'(found), JW'(1));
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_outputs", JW'({in_ready, mac_valid, res_valid, err_timeout, jobs_done, res_data}),
            JW'({1'b1, 1'b0, 1'b0, 1'b0, 16'd0, RW'(0)}));
        chk("midrst_mac_ops", {mac_c, mac_b, mac_a}, JW'(0));
        n_mv = 0; found = 0;
        repeat (60) begin
            @(negedge clk);
            if (mac_valid) n_mv++;
            if (res_valid) found = 1;
        end
        chk("midrst_no_issue", JW'(n_mv), JW'(0));
        chk("midrst_no_result", JW'(found), JW'(0));

        // Keep in_valid high while the queue is full and the head is popped
        sub_log.delete();
        fixed_lat   = 20;
        submit_left = 4;
        run_collect(300, res_log, saw_full);
        chk("full_saw_full", JW'(saw_full), JW'(1));
        chk("full_results", JW'(res_log.size()), JW'(4));
        for (int i = 0; i < res_log.size() && i < sub_log.size(); i++) begin
            chk("full_order", JW'(res_log[i]), JW'(mac_fn(sub_log[i])));
        end

        // Randomized traffic with an unannounced reset in the middle
        fixed_lat   = -1;
        p_valid     = 30;
        p_ready     = 60;
        p_spur      = 3;
        submit_left = 1000000;
        repeat (2000) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2000) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
